// File: rtl/serial_subtractor_if.sv
// Host-side handshake and data bundle for serial_subtractor.
// The host drives the operands and start; the subtractor returns result and status.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  diff, bout, busy, done, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, busy, done, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first, one bit per clock.
// A single full-subtractor cell feeds a registered borrow; the result word is
// assembled by shifting each difference bit in at the MSB.
// Optional signed-overflow flag is built only when SERSUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic x_bit, y_bit, d_bit, br_next;

    // Full-subtractor cell on the current operand LSBs and stored borrow
    always_comb begin
        x_bit   = sa_q[0];
        y_bit   = sb_q[0];
        d_bit   = x_bit ^ y_bit ^ br_q;
        br_next = (~x_bit & y_bit) | (~x_bit & br_q) | (y_bit & br_q);
    end

    // Next-state, shift and result-capture logic
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bout_d  = br_next;
`ifdef SERSUB_OVF_EN
                    ovf_d   = (x_bit != y_bit) & (d_bit != x_bit);
`endif
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
`ifdef SERSUB_OVF_EN
    assign bus.ovf  = ovf_q;
`else
    assign bus.ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issue one start, then wait for done; returns latency and busy-cycle count.
    task automatic do_run(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cnt++;
        end
        if (!bus.done) begin
            checks++;
            $display("FAIL run_timeout: done=%b after %0d cycles, required done=1", bus.done, lat);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        #12;
        checks++; if (bus.diff !== 8'h00) $display("FAIL reset_diff: got %h required 00", bus.diff); else passes++;
        checks++; if ({bus.bout, bus.busy, bus.done, bus.ovf} !== 4'b0000)
            $display("FAIL reset_flags: got %b required 0000", {bus.bout, bus.busy, bus.done, bus.ovf});
        else passes++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bc;
        do_run(8'd100, 8'd37, 1'b0, lat, bc);
        checks++; if (lat !== 8) $display("FAIL basic_latency: got %0d required 8", lat); else passes++;
        checks++; if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d required 8", bc); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b required 0", bus.busy); else passes++;
        checks++; if (bus.diff !== 8'h3F) $display("FAIL basic_diff: got %h required 3F", bus.diff); else passes++;
        checks++; if (bus.bout !== 1'b0) $display("FAIL basic_bout: got %b required 0", bus.bout); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) $display("FAIL done_pulse_width: got %b required 0", bus.done); else passes++;
        checks++; if (bus.diff !== 8'h3F) $display("FAIL diff_hold_idle: got %h required 3F", bus.diff); else passes++;
    endtask

    task automatic test_vectors;
        logic [7:0] va [5] = '{8'd5,  8'h00, 8'hFF, 8'h80, 8'h10};
        logic [7:0] vb [5] = '{8'd10, 8'h00, 8'hFF, 8'h01, 8'h01};
        logic       vi [5] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        logic [7:0] ed [5] = '{8'hFB, 8'hFF, 8'h00, 8'h7F, 8'h0F};
        logic       eb [5] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
`ifdef SERSUB_OVF_EN
        logic       eo [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
`else
        logic       eo [5] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
`endif
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            do_run(va[i], vb[i], vi[i], lat, bc);
            checks++; if (bus.diff !== ed[i]) $display("FAIL vec%0d_diff: got %h required %h", i, bus.diff, ed[i]); else passes++;
            checks++; if (bus.bout !== eb[i]) $display("FAIL vec%0d_bout: got %b required %b", i, bus.bout, eb[i]); else passes++;
            checks++; if (bus.ovf !== eo[i]) $display("FAIL vec%0d_ovf: got %b required %b", i, bus.ovf, eo[i]); else passes++;
        end
    endtask

    task automatic test_start_ignored;
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd37; bus.bin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk); @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd10; bus.bin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (bus.diff !== 8'h3F) $display("FAIL ignore_start_diff: got %h required 3F", bus.diff); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL ignore_start_no_rerun: busy=%b required 0", bus.busy); else passes++;
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd37; bus.bin = 1'b0;
        @(posedge clk); #1;
        bus.a = 8'd5; bus.b = 8'd10;
        n = 0;
        while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (bus.diff !== 8'h3F) $display("FAIL b2b_first_diff: got %h required 3F", bus.diff); else passes++;
        n = 0;
        @(posedge clk); #1;
        n++;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_no_bubble: busy=%b required 1", bus.busy); else passes++;
        while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 9) $display("FAIL b2b_spacing: got %0d required 9", n); else passes++;
        checks++; if (bus.diff !== 8'hFB) $display("FAIL b2b_second_diff: got %h required FB", bus.diff); else passes++;
        checks++; if (bus.bout !== 1'b1) $display("FAIL b2b_second_bout: got %b required 1", bus.bout); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, seen;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h0F; bus.bin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done, bus.bout, bus.ovf} !== 4'b0000)
            $display("FAIL midrun_reset_flags: got %b required 0000", {bus.busy, bus.done, bus.bout, bus.ovf});
        else passes++;
        checks++; if (bus.diff !== 8'h00) $display("FAIL midrun_reset_diff: got %h required 00", bus.diff); else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (bus.done || bus.busy) seen++; end
        checks++; if (seen !== 0) $display("FAIL midrun_no_done: active cycles %0d required 0", seen); else passes++;
        do_run(8'h10, 8'h01, 1'b0, lat, bc);
        checks++; if (bus.diff !== 8'h0F) $display("FAIL after_reset_diff: got %h required 0F", bus.diff); else passes++;
        checks++; if (lat !== 8) $display("FAIL after_reset_latency: got %0d required 8", lat); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing a - b - bin, LSB first, one bit per clock through a single full-subtractor cell and a registered borrow. Sits downstream of the combinational full-subtractor stage: consumes its difference/borrow equations each cycle and assembles them into a parallel word. Used where area matters more than latency; start/done handshake for a host controller.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  minuend; captured on accepted start
b      input   WIDTH  subtrahend; captured on accepted start
bin    input   1      borrow-in; captured on accepted start
diff   output  WIDTH  result a - b - bin (mod 2^WIDTH), valid while done/IDLE after a run
bout   output  1      final borrow out
busy   output  1      high in RUN
done   output  1      one-cycle pulse, result valid
ovf    output  1      signed overflow (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=IDLE; diff=0, bout=0, busy=0, done=0, ovf=0; operand shift regs, borrow reg, bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> load sa<=a, sb<=b, br<=bin, cnt<=0, state<=RUN. start=0 -> stay.
- RUN (edges k+1 .. k+WIDTH): per edge, with x=sa[0], y=sb[0]:
  d = x ^ y ^ br; br <= (~x & y) | (~x & br) | (y & br);
  diff shifts right, d enters MSB; sa, sb shift right; cnt++.
  On the edge where cnt==WIDTH-1: bout<=next br, state<=DONE. start ignored throughout RUN.
- DONE (one cycle, entered at edge k+WIDTH): done=1, busy=0. Next edge: start=1 -> accept new operands exactly as from IDLE (back-to-back, no idle bubble); else -> IDLE.
- Latency: done high WIDTH edges after the accepting edge; throughput one result per WIDTH+1 cycles.
- diff/bout/ovf hold their final values through DONE and IDLE until the next accepted start; during RUN diff holds partial shifted data (not valid).
- busy and done are decoded from registered state; never both high.
- Reset asserted mid-RUN: run is aborted, all outputs return to reset values, no done pulse.
- Borrow chain: bin participates as the borrow into bit 0 only.

Optional Feature:
SERSUB_OVF_EN: when defined, the MSB step also registers ovf <= (x != y) & (d != x) (two's-complement overflow of a - b - bin), updated with bout, held like diff. When undefined, ovf is tied to 0 and no extra logic is built.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, start at edge k -> done at edge k+8, diff=8'h3F (63), bout=0, busy high edges k+1..k+7.
- a=5, b=10, bin=0 -> diff=8'hFB, bout=1.
- a=0, b=0, bin=1 -> diff=8'hFF, bout=1; a=8'hFF, b=8'hFF, bin=0 -> diff=0, bout=0.
- start pulsed during RUN with different operands -> ignored, first result unchanged; start held high in DONE -> second run starts next edge, second done exactly 9 cycles after first.
- rst asserted at edge k+4 of a run -> outputs 0 immediately, state IDLE, no done; new start afterwards completes normally.
- SERSUB_OVF_EN defined: a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, ovf=1, bout=0; a=8'h10, b=8'h01 -> ovf=0. Undefined: ovf=0 for both.
